gray_arbiter: RTL and testbench

GRAY_ARBITER -- requirements
Module: gray_arbiter

---
 rtl/gray_arbiter.sv | 119 +++++++++++
 tb/tb_gray_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/gray_arbiter.sv
// Two-requester read arbiter in front of a single-port gray pixel memory.
// Bursts up to MAX_BURST beats per tenure, then hands over round-robin with no idle gap.
module gray_arbiter #(
  parameter int AW        = 14,
  parameter int DW        = 8,
  parameter int MAX_BURST = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          gray_ready,
  output logic          gray_req,
  output logic [AW-1:0] gray_addr,
  input  logic [DW-1:0] gray_data,
  input  logic          req_a,
  input  logic          req_b,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          rvalid_a,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b,
  output logic          busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OWN_A = 2'd1;
  localparam logic [1:0] S_OWN_B = 2'd2;
  localparam logic [3:0] MAXC    = 4'(MAX_BURST);

  logic [1:0] r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_rr, w_rr_nxt;
  logic       r_rva, r_rvb, r_busy;
  logic       w_gnt_a, w_gnt_b;
  logic       w_mine, w_own_req, w_oth_req;

  // w_mine: 0 when A owns, 1 when B owns; lets one branch serve both owners
  assign w_mine    = (r_state == S_OWN_B);
  assign w_own_req = w_mine ? req_b : req_a;
  assign w_oth_req = w_mine ? req_a : req_b;

  always_comb begin
    w_gnt_a     = 1'b0;
    w_gnt_b     = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rr_nxt    = r_rr;
    if (reset && gray_ready) begin
      case (r_state)
        S_IDLE: begin
          if (req_a && (!req_b || !r_rr)) begin
            w_gnt_a     = 1'b1;
            w_state_nxt = S_OWN_A;
            w_cnt_nxt   = 4'd1;
          end else if (req_b) begin
            w_gnt_b     = 1'b1;
            w_state_nxt = S_OWN_B;
            w_cnt_nxt   = 4'd1;
          end else begin
            w_cnt_nxt   = 4'd0;
          end
        end
        S_OWN_A, S_OWN_B: begin
          if (w_own_req && (r_cnt < MAXC || !w_oth_req)) begin
            w_gnt_a   = !w_mine;
            w_gnt_b   = w_mine;
            w_cnt_nxt = (r_cnt < MAXC) ? r_cnt + 4'd1 : 4'd1;
          end else if (w_oth_req) begin
            // handover: rr points away from the new owner
            w_gnt_a     = w_mine;
            w_gnt_b     = !w_mine;
            w_state_nxt = w_mine ? S_OWN_A : S_OWN_B;
            w_cnt_nxt   = 4'd1;
            w_rr_nxt    = w_mine;
          end else begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 4'd0;
            w_rr_nxt    = !w_mine;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_rr    <= 1'b0;
      r_rva   <= 1'b0;
      r_rvb   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rr    <= w_rr_nxt;
      r_rva   <= w_gnt_a;
      r_rvb   <= w_gnt_b;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  assign gnt_a     = w_gnt_a;
  assign gnt_b     = w_gnt_b;
  assign gray_req  = w_gnt_a | w_gnt_b;
  assign gray_addr = w_gnt_a ? addr_a : (w_gnt_b ? addr_b : '0);
  assign rvalid_a  = r_rva;
  assign rvalid_b  = r_rvb;
  assign rdata_a   = r_rva ? gray_data : '0;
  assign rdata_b   = r_rvb ? gray_data : '0;
  assign busy      = r_busy;

endmodule

// File: tb/tb_gray_arbiter.sv
// Scoreboard bench for gray_arbiter: a behavioural arbiter model predicts grants,
// each grant pushes its expected read beat, popped when the read returns.
module tb_gray_arbiter;
  localparam int AW = 14;
  localparam int DW = 8;
  localparam int MB = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          gray_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic [DW-1:0] gray_data;
  logic          req_a, req_b;
  logic [AW-1:0] addr_a, addr_b;
  logic          gnt_a, gnt_b, rvalid_a, rvalid_b, busy;
  logic [DW-1:0] rdata_a, rdata_b;

  gray_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .gray_ready(gray_ready), .gray_req(gray_req),
    .gray_addr(gray_addr), .gray_data(gray_data), .req_a(req_a), .req_b(req_b),
    .addr_a(addr_a), .addr_b(addr_b), .gnt_a(gnt_a), .gnt_b(gnt_b),
    .rvalid_a(rvalid_a), .rvalid_b(rvalid_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mfn(input logic [AW-1:0] a);
    return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h5A;
  endfunction

  // gray memory: one-cycle read latency
  logic [DW-1:0] mem_q = '0;
  always_ff @(posedge clk) if (gray_req) mem_q <= mfn(gray_addr);
  assign gray_data = mem_q;

  typedef struct packed { logic b; logic [DW-1:0] d; } rd_t;
  rd_t sb[$];

  int n_tot = 0, n_bad = 0;
  int m_st = 0, m_cnt = 0;   // 0 idle, 1 own A, 2 own B
  bit m_rr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_gnt"}, {gnt_b, gnt_a}, 0);
    chk({tag, "_req"}, gray_req, 0);
    chk({tag, "_addr"}, gray_addr, 0);
    chk({tag, "_rv"}, {rvalid_b, rvalid_a}, 0);
    chk({tag, "_rd"}, {rdata_b, rdata_a}, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // called at negedge; reset is applied mid low phase, with no clock edge before the check
  task automatic do_reset(input string tag);
    #2 reset = 1'b0;
    #1 rst_chk({tag, "_async"});
    m_st = 0; m_cnt = 0; m_rr = 1'b0;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_chk({tag, "_held"});
    reset = 1'b1;
  endtask

  // one cycle; xg = directed grant expectation (-1 none, 0 idle, 1 A, 2 B)
  task automatic step(input int xg = -1);
    bit ga, gb, own, oth;
    int ns, nc;
    bit nr;
    logic [AW-1:0] ea;
    rd_t e;
    #1;
    ga = 0; gb = 0; ns = m_st; nc = m_cnt; nr = m_rr;
    if (gray_ready) begin
      if (m_st == 0) begin
        if (req_a && req_b) begin ga = !m_rr; gb = m_rr; end
        else begin ga = req_a; gb = req_b; end
        if (ga) begin ns = 1; nc = 1; end
        else if (gb) begin ns = 2; nc = 1; end
        else nc = 0;
      end else begin
        own = (m_st == 1) ? req_a : req_b;
        oth = (m_st == 1) ? req_b : req_a;
        if (own && m_cnt < MB) begin
          nc = m_cnt + 1;
          if (m_st == 1) ga = 1; else gb = 1;
        end else if (own && !oth) begin
          nc = 1;
          if (m_st == 1) ga = 1; else gb = 1;
        end else if (oth) begin
          ns = (m_st == 1) ? 2 : 1;
          nc = 1;
          nr = (ns == 1);
          if (ns == 1) ga = 1; else gb = 1;
        end else begin
          ns = 0; nc = 0;
          nr = (m_st == 1);
        end
      end
    end
    ea = ga ? addr_a : (gb ? addr_b : '0);
    chk("gnt_a", gnt_a, ga);
    chk("gnt_b", gnt_b, gb);
    chk("gray_req", gray_req, ga | gb);
    chk("gray_addr", gray_addr, ea);
    chk("busy", busy, m_st != 0);
    if (xg >= 0) chk("dir_gnt", {gnt_b, gnt_a}, xg);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rvalid", {rvalid_b, rvalid_a}, e.b ? 2 : 1);
      chk("rdata", e.b ? rdata_b : rdata_a, e.d);
      chk("rdata_idle", e.b ? rdata_a : rdata_b, 0);
    end else begin
      chk("rvalid_idle", {rvalid_b, rvalid_a}, 0);
      chk("rdata_zero", {rdata_b, rdata_a}, 0);
    end
    @(posedge clk);
    m_st = ns; m_cnt = nc; m_rr = nr;
    if (ga) sb.push_back('{b: 1'b0, d: mfn(addr_a)});
    if (gb) sb.push_back('{b: 1'b1, d: mfn(addr_b)});
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; gray_ready = 1'b1; req_a = 1'b1; req_b = 1'b1;
    addr_a = 14'd77; addr_b = 14'd88;
    #2 rst_chk("por");
    @(negedge clk);
    @(negedge clk);
    rst_chk("por_clk");
    reset = 1'b1;

    // both request: 9 A beats, 9 B beats, back to A with no gap
    for (int i = 0; i < 20; i++) begin
      addr_a = 14'(100 + i); addr_b = 14'(200 + i);
      step(i < 9 ? 1 : (i < 18 ? 2 : 1));
    end

    // A alone streams 129..148 and keeps ownership past MAX_BURST
    do_reset("r1");
    req_b = 1'b0;
    for (int i = 0; i < 20; i++) begin
      addr_a = 14'(129 + i);
      step(1);
    end
    req_a = 1'b0;
    step(0);

    // A drops at cnt=4 while B requests: same-cycle handover
    do_reset("r2");
    req_a = 1'b1; req_b = 1'b0;
    for (int i = 0; i < 4; i++) begin addr_a = 14'(300 + i); step(1); end
    req_a = 1'b0; req_b = 1'b1; addr_b = 14'd400;
    step(2);
    req_b = 1'b0;
    step(0);
    step(0);

    // memory stall at cnt=5 holds the burst count
    do_reset("r3");
    req_a = 1'b1; req_b = 1'b1;
    for (int i = 0; i < 5; i++) begin addr_a = 14'(500 + i); step(1); end
    gray_ready = 1'b0;
    for (int i = 0; i < 3; i++) step(0);
    gray_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin addr_a = 14'(600 + i); step(1); end
    addr_b = 14'd700;
    step(2);

    // both drop in OWN_B, then both request: A wins
    do_reset("r4");
    req_a = 1'b0; req_b = 1'b1;
    for (int i = 0; i < 3; i++) begin addr_b = 14'(800 + i); step(2); end
    req_b = 1'b0;
    step(0);
    step(0);
    req_a = 1'b1; req_b = 1'b1; addr_a = 14'd900;
    step(1);
    step(1);

    // reset right after a B grant discards the in-flight read
    do_reset("r5");
    req_a = 1'b0; req_b = 1'b1; addr_b = 14'd16126;
    step(2);
    do_reset("r6");
    req_b = 1'b0;
    for (int i = 0; i < 3; i++) step(0);

    // random traffic with stalls
    for (int i = 0; i < 300; i++) begin
      req_a = ($urandom_range(0, 3) != 0);
      req_b = ($urandom_range(0, 3) != 0);
      gray_ready = ($urandom_range(0, 4) != 0);
      addr_a = 14'($urandom);
      addr_b = 14'($urandom);
      step();
    end
    req_a = 1'b0; req_b = 1'b0; gray_ready = 1'b1;
    step();
    step();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
